// File: rtl/alu_cmd_issuer_if.sv
// Command, ALU and result bus of the ALU issue stage.
// slave = issue stage side, master = command source / ALU / result consumer side.
interface alu_cmd_issuer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;

    logic        alu_en;
    logic        alu_start;
    logic [3:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_z_low;
    logic [15:0] alu_z_high;
    logic        alu_valid;

    logic        res_valid;
    logic        res_ready;
    logic [3:0]  res_op;
    logic [15:0] res_z_low;
    logic [15:0] res_z_high;
    logic        res_err;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b,
        output cmd_ready,
        output alu_en, alu_start, alu_op, alu_a, alu_b,
        input  alu_z_low, alu_z_high, alu_valid,
        output res_valid, res_op, res_z_low, res_z_high, res_err,
        input  res_ready
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b,
        input  cmd_ready,
        input  alu_en, alu_start, alu_op, alu_a, alu_b,
        output alu_z_low, alu_z_high, alu_valid,
        input  res_valid, res_op, res_z_low, res_z_high, res_err,
        output res_ready
    );
endinterface

// File: rtl/alu_cmd_issuer.sv
// FIFO-buffered issue stage for the 16-bit ALU: one op in flight, result register, ALU clock-gate control.
// Define ALU_ISSUE_STATS_EN to add the stat_ops / stat_gated counters.
module alu_cmd_issuer #(
    parameter int DEPTH     = 4,
    parameter int FIXED_LAT = 1,
    parameter int TIMEOUT   = 64,
    parameter int IDLE_GATE = 2
) (
    input  logic clk,
    input  logic rst,
`ifdef ALU_ISSUE_STATS_EN
    output logic [15:0] stat_ops,
    output logic [15:0] stat_gated,
`endif
    output logic busy,
    alu_cmd_issuer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT + FIXED_LAT + 1);
    localparam int IW = $clog2(IDLE_GATE + 1);
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;

    typedef enum logic [2:0] {S_IDLE, S_WAKE, S_ISSUE, S_WAIT, S_HOLD} state_t;
    state_t state_reg, state_next;

    logic [35:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          full, empty, push, pop;

    logic [CW-1:0] wait_cnt_reg;
    logic [IW-1:0] idle_cnt_reg, idle_cnt_next;
    logic          en_reg, en_next;
    logic          cap, cap_err, is_long;

    logic [3:0]    alu_op_reg;
    logic [15:0]   alu_a_reg, alu_b_reg;
    logic [3:0]    res_op_reg;
    logic [15:0]   res_z_low_reg, res_z_high_reg;
    logic          res_err_reg;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push    = bus.cmd_valid && !full;
    assign pop     = (state_next == S_ISSUE);
    assign is_long = (alu_op_reg == OP_MUL) || (alu_op_reg == OP_DIV);

    always_comb begin
        state_next = state_reg;
        cap        = 1'b0;
        cap_err    = 1'b0;
        case (state_reg)
            S_IDLE:  if (!empty) state_next = en_reg ? S_ISSUE : S_WAKE;
            S_WAKE:  state_next = S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT: begin
                // Only MUL/DIV report completion; everything else is a fixed-latency sample.
                if (is_long) begin
                    if (bus.alu_valid)
                        cap = 1'b1;
                    else if (wait_cnt_reg == CW'(TIMEOUT - 1))
                        cap_err = 1'b1;
                end else if (wait_cnt_reg == CW'(FIXED_LAT - 1)) begin
                    cap = 1'b1;
                end
                if (cap || cap_err) state_next = S_HOLD;
            end
            S_HOLD:  if (bus.res_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        idle_cnt_next = idle_cnt_reg;
        en_next       = en_reg;
        if (push || state_reg != S_IDLE || !empty)
            idle_cnt_next = '0;
        else if (idle_cnt_reg != IW'(IDLE_GATE))
            idle_cnt_next = idle_cnt_reg + 1'b1;
        // Wake raises the enable a cycle ahead of the start pulse.
        if (state_next == S_WAKE)
            en_next = 1'b1;
        else if (state_reg == S_IDLE && empty && !push && idle_cnt_reg == IW'(IDLE_GATE - 1))
            en_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            wait_cnt_reg   <= '0;
            idle_cnt_reg   <= '0;
            en_reg         <= 1'b1;
            alu_op_reg     <= '0;
            alu_a_reg      <= '0;
            alu_b_reg      <= '0;
            res_op_reg     <= '0;
            res_z_low_reg  <= '0;
            res_z_high_reg <= '0;
            res_err_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idle_cnt_reg <= idle_cnt_next;
            en_reg       <= en_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
                {alu_op_reg, alu_a_reg, alu_b_reg} <= mem[rd_ptr_reg];
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (state_reg == S_ISSUE)
                wait_cnt_reg <= '0;
            else if (state_reg == S_WAIT)
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            if (cap) begin
                res_op_reg     <= alu_op_reg;
                res_z_low_reg  <= bus.alu_z_low;
                res_z_high_reg <= bus.alu_z_high;
                res_err_reg    <= 1'b0;
            end else if (cap_err) begin
                res_op_reg     <= alu_op_reg;
                res_z_low_reg  <= '0;
                res_z_high_reg <= '0;
                res_err_reg    <= 1'b1;
            end
        end
    end

    assign bus.cmd_ready  = !full;
    assign bus.alu_en     = en_reg;
    assign bus.alu_start  = (state_reg == S_ISSUE);
    assign bus.alu_op     = alu_op_reg;
    assign bus.alu_a      = alu_a_reg;
    assign bus.alu_b      = alu_b_reg;
    assign bus.res_valid  = (state_reg == S_HOLD);
    assign bus.res_op     = res_op_reg;
    assign bus.res_z_low  = res_z_low_reg;
    assign bus.res_z_high = res_z_high_reg;
    assign bus.res_err    = res_err_reg;
    assign busy           = (state_reg != S_IDLE) || !empty;

`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] stat_ops_reg, stat_gated_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops_reg   <= '0;
            stat_gated_reg <= '0;
        end else begin
            if (state_reg == S_HOLD && bus.res_ready && stat_ops_reg != 16'hFFFF)
                stat_ops_reg <= stat_ops_reg + 16'd1;
            if (!en_reg && stat_gated_reg != 16'hFFFF)
                stat_gated_reg <= stat_gated_reg + 16'd1;
        end
    end

    assign stat_ops   = stat_ops_reg;
    assign stat_gated = stat_gated_reg;
`endif
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: directed cases plus randomized traffic against a queue-based reference
// and a behavioural ALU stand-in that only presents a correct Z on the cycle it is due.
module tb_alu_cmd_issuer;
    localparam int DEPTH     = 4;
    localparam int FIXED_LAT = 1;
    localparam int TIMEOUT   = 64;
    localparam int IDLE_GATE = 2;
    localparam int NRAND     = 40;

    logic clk = 1'b0;
    logic rst;
    logic busy;
`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] stat_ops, stat_gated;
`endif

    alu_cmd_issuer_if bus();

    alu_cmd_issuer #(.DEPTH(DEPTH), .FIXED_LAT(FIXED_LAT), .TIMEOUT(TIMEOUT), .IDLE_GATE(IDLE_GATE)) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef ALU_ISSUE_STATS_EN
        .stat_ops   (stat_ops),
        .stat_gated (stat_gated),
`endif
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] z;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   n_res = 0;
    int   start_cnt = 0;

    // ALU stand-in controls
    int          k = 1000;
    int          delay = 1;
    int          fixed_delay = 0;
    bit          hang = 1'b0;
    bit          force_valid = 1'b0;
    logic [31:0] r;

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        int sa, sb;
        logic [16:0] s;
        case (op)
            4'b0000: begin s = {1'b0, a} + {1'b0, b}; return {15'd0, s}; end
            4'b0001: return {16'd0, a - b};
            4'b0010: begin sa = int'($signed(a)); sb = int'($signed(b)); return sa * sb; end
            4'b0011: return (b == 16'd0) ? 32'hFFFF_FFFF : {a % b, a / b};
            4'b0100: return {16'd0, a & b};
            4'b0101: return {16'd0, a | b};
            4'b0110: return {16'd0, a ^ b};
            default: return {16'd0, ~a};
        endcase
    endfunction

    always @(negedge clk) begin
        if (bus.alu_start) begin
            k = 0;
            delay = (fixed_delay != 0) ? fixed_delay : $urandom_range(1, 20);
        end else if (k < 100000) begin
            k++;
        end
        r = alu_ref(bus.alu_op, bus.alu_a, bus.alu_b);
        if (bus.alu_op == 4'b0010 || bus.alu_op == 4'b0011) begin
            bus.alu_valid = (!hang && k == delay);
            if (!(!hang && k == delay)) r = 32'hDEAD_BEEF;
        end else begin
            bus.alu_valid = ($urandom_range(0, 1) == 1);
            if (k != FIXED_LAT) r = 32'hDEAD_BEEF;
        end
        if (force_valid) bus.alu_valid = 1'b1;
        bus.alu_z_low  = r[15:0];
        bus.alu_z_high = r[31:16];
        if (bus.alu_start) start_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // mode 0: normal result expected, 1: timeout result expected, 2: no result (abandoned)
    task automatic push_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input int mode);
        int n = 0;
        exp_t e;
        bus.cmd_valid = 1'b1;
        bus.cmd_op = op;
        bus.cmd_a = a;
        bus.cmd_b = b;
        while (!bus.cmd_ready && n < 500) begin tick(); n++; end
        if (n >= 500) begin
            chk("push_ready", {31'd0, bus.cmd_ready}, 32'd1);
            bus.cmd_valid = 1'b0;
            return;
        end
        tick();
        bus.cmd_valid = 1'b0;
        e.op = op;
        e.z = (mode == 1) ? 32'd0 : alu_ref(op, a, b);
        e.err = (mode == 1);
        if (mode != 2) exp_q.push_back(e);
    endtask

    task automatic get_res(input string tag, input int dly);
        int n = 0;
        exp_t e;
        while (!bus.res_valid && n < 400) begin tick(); n++; end
        chk($sformatf("%s_valid", tag), {31'd0, bus.res_valid}, 32'd1);
        if (exp_q.size() == 0) begin
            chk($sformatf("%s_unexpected", tag), 32'(exp_q.size()), 32'd1);
            return;
        end
        e = exp_q.pop_front();
        repeat (dly) tick();
        chk($sformatf("%s_op", tag), {28'd0, bus.res_op}, {28'd0, e.op});
        chk($sformatf("%s_z", tag), {bus.res_z_high, bus.res_z_low}, e.z);
        chk($sformatf("%s_err", tag), {31'd0, bus.res_err}, {31'd0, e.err});
        $display("result %s op=%0h z=%h err=%0b", tag, bus.res_op, {bus.res_z_high, bus.res_z_low}, bus.res_err);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        n_res++;
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (!bus.alu_start && n < 100) begin tick(); n++; end
        chk($sformatf("%s_start", tag), {31'd0, bus.alu_start}, 32'd1);
    endtask

    task automatic measure_lat(input string tag, input int expv);
        int n = 0;
        while (!bus.res_valid && n < 300) begin tick(); n++; end
        chk($sformatf("%s_lat", tag), 32'(n), 32'(expv));
    endtask

    initial begin
        int n_at_rst;
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = '0;
        bus.cmd_a = '0;
        bus.cmd_b = '0;
        bus.res_ready = 1'b0;
        repeat (3) tick();

        // reset state
        chk("rst_start", {31'd0, bus.alu_start}, 32'd0);
        chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("rst_res_err", {31'd0, bus.res_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_en", {31'd0, bus.alu_en}, 32'd1);
        chk("rst_buses", {bus.alu_op, bus.alu_a, bus.res_z_low}, 36'd0);
        chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);

        // T1 ADD with minimum latency
        rst = 1'b0;
        push_cmd(4'b0000, 16'd100, 16'd25, 0);
        tick();
        chk("t1_start", {31'd0, bus.alu_start}, 32'd1);
        chk("t1_alu_ab", {bus.alu_a, bus.alu_b}, {16'd100, 16'd25});
        repeat (FIXED_LAT) tick();
        chk("t1_start_once", {31'd0, bus.alu_start}, 32'd0);
        chk("t1_not_yet", {31'd0, bus.res_valid}, 32'd0);
        tick();
        chk("t1_valid", {31'd0, bus.res_valid}, 32'd1);
        chk("t1_zlow", {16'd0, bus.res_z_low}, 32'h007D);
        get_res("t1", 0);

        // T2 MUL completing after 17 cycles
        fixed_delay = 17;
        push_cmd(4'b0010, -16'sd15000, -16'sd12000, 0);
        wait_start("t2");
        measure_lat("t2", 18);
        chk("t2_z", {bus.res_z_high, bus.res_z_low}, 32'h0ABA_9500);
        get_res("t2", 2);
        fixed_delay = 0;

        // T3 FIFO full under back-pressure, order preserved
        for (int i = 0; i < DEPTH + 1; i++)
            push_cmd(4'(i % 8 == 2 ? 0 : i % 8), 16'(i * 37 + 5), 16'(i + 3), 0);
        chk("t3_full", {31'd0, bus.cmd_ready}, 32'd0);
        bus.cmd_valid = 1'b1;
        repeat (3) tick();
        chk("t3_still_full", {31'd0, bus.cmd_ready}, 32'd0);
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) get_res("t3", 0);
        repeat (3) tick();
        chk("t3_no_dup", {31'd0, bus.res_valid}, 32'd0);
        chk("t3_idle", {31'd0, busy}, 32'd0);

        // T4 clock gating and wake-up
        repeat (IDLE_GATE + 2) tick();
        chk("t4_gated", {31'd0, bus.alu_en}, 32'd0);
        push_cmd(4'b0001, 16'd250, 16'd50, 0);
        tick();
        chk("t4_wake_en", {31'd0, bus.alu_en}, 32'd1);
        chk("t4_wake_nostart", {31'd0, bus.alu_start}, 32'd0);
        tick();
        chk("t4_start", {31'd0, bus.alu_start}, 32'd1);
        repeat (FIXED_LAT + 1) tick();
        chk("t4_zlow", {16'd0, bus.res_z_low}, 32'h00C8);
        get_res("t4", 0);

        // T5 DIV timeout
        hang = 1'b1;
        push_cmd(4'b0011, 16'd100, 16'd3, 1);
        wait_start("t5");
        measure_lat("t5", TIMEOUT + 1);
        get_res("t5", 0);

        // T6 reset while waiting on MUL; a late valid must be ignored
        push_cmd(4'b0010, 16'd7, 16'd9, 2);
        wait_start("t6");
        repeat (3) tick();
        push_cmd(4'b0000, 16'd1, 16'd2, 2);
        push_cmd(4'b0000, 16'd3, 16'd4, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_at_rst = n_res;
        force_valid = 1'b1;
        tick();
        force_valid = 1'b0;
        hang = 1'b0;
        chk("t6_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_en", {31'd0, bus.alu_en}, 32'd1);
        repeat (4) tick();
        chk("t6_no_issue", {31'd0, bus.res_valid, busy}, 32'd0);

        // randomized traffic with back-pressure
        fork
            begin
                for (int i = 0; i < NRAND; i++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    push_cmd(4'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 0);
                end
            end
            begin
                for (int j = 0; j < NRAND; j++) get_res("rnd", $urandom_range(0, 3));
            end
        join
        repeat (3) tick();
        chk("end_idle", {31'd0, busy}, 32'd0);
        chk("start_count", 32'(start_cnt), 32'(n_res + 1));
`ifdef ALU_ISSUE_STATS_EN
        chk("stat_ops", {16'd0, stat_ops}, 32'(n_res - n_at_rst));
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete, limit=2000000");
        $fatal(1, "watchdog");
    end
endmodule
